// File: rtl/serial_addsub_unit.sv
// Digit-serial N-bit adder/subtractor: W bits per clock, LSB first, with
// start/done handshake, carry/borrow out, signed overflow and zero flags.
module serial_addsub_unit #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int D  = N / W;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_c;
  logic          r_mode;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_res;
  logic          r_cout;
  logic          r_ovf;

  logic [W-1:0]  w_ad;
  logic [W-1:0]  w_bd;
  logic [W:0]    w_sum;
  logic          w_last;

  // Subtraction is a + ~b + ~borrow; the carry register holds the inverted borrow.
  assign w_ad   = r_a[r_cnt*W +: W];
  assign w_bd   = r_mode ? ~r_b[r_cnt*W +: W] : r_b[r_cnt*W +: W];
  assign w_sum  = {1'b0, w_ad} + {1'b0, w_bd} + {{W{1'b0}}, r_c};
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_mode  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_c     <= mode ? ~cin : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res[r_cnt*W +: W] <= w_sum[W-1:0];
          r_c                 <= w_sum[W];
          if (w_last) begin
            r_state <= S_DONE;
            r_cout  <= r_mode ? ~w_sum[W] : w_sum[W];
            // w_sum[W-1] is the result MSB being written on this edge.
            r_ovf   <= (r_mode ? (r_a[N-1] != r_b[N-1]) : (r_a[N-1] == r_b[N-1]))
                       && (w_sum[W-1] != r_a[N-1]);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_res;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = (r_res == '0);

endmodule
